// File: rtl/aq_vdsp_ff1_scan_ctrl_if.sv
// Handshake bundle between a requester and aq_vdsp_ff1_scan_ctrl.
//   flush                       : kill the in-flight operation
//   req_vld/req_rdy/req_src/
//   req_signed                  : operand request channel
//   res_vld/res_rdy/res_lzc/
//   res_zero/res_rem            : result channel
// master drives requests and consumes results; slave is the sequencer.
interface aq_vdsp_ff1_scan_ctrl_if #(
    parameter int WIDTH = 64
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             flush;
    logic             req_vld;
    logic             req_rdy;
    logic [WIDTH-1:0] req_src;
    logic             req_signed;
    logic             res_vld;
    logic             res_rdy;
    logic [CW-1:0]    res_lzc;
    logic             res_zero;
    logic             res_rem;

    modport master (
        output flush, req_vld, req_src, req_signed, res_rdy,
        input  req_rdy, res_vld, res_lzc, res_zero, res_rem
    );

    modport slave (
        input  flush, req_vld, req_src, req_signed, res_rdy,
        output req_rdy, res_vld, res_lzc, res_zero, res_rem
    );
endinterface

// File: rtl/aq_vdsp_ff1_scan_ctrl.sv
// Leading-zero / leading-sign count sequencer for wide divider operands.
// Scans the operand one byte per cycle, MSB byte first, through a single
// 8-bit find-first-one unit, and stops early once the "all bits below the
// leading one are 1" flag is known to be 0.
// Ports:
//   forever_cpuclk : clock
//   cpurst_b       : synchronous active-low reset
//   bus            : slave side of aq_vdsp_ff1_scan_ctrl_if (flush,
//                    request valid/ready channel, result valid/ready channel)

// 8-bit find-first-one.
//   src  : input byte
//   out  : (leading-zero count - 1) mod 8, so out+1 mod 8 is the count
//   zero : src == 0
//   rem  : all bits below the leading one are 1 (1 when src == 0)
module aq_vdsp_8_bit_ff1 (
    input  logic [7:0] src,
    output logic [2:0] out,
    output logic       zero,
    output logic       rem
);
    logic [2:0] pos;
    logic [7:0] mask;

    always_comb begin
        pos = '0;
        // Ascending scan: the last hit is the most significant one.
        for (int unsigned i = 0; i < 8; i++) begin
            if (src[i]) pos = i[2:0];
        end
        zero = (src == '0);
        mask = (8'd1 << pos) - 8'd1;
        rem  = zero | ((src & mask) == mask);
        out  = 3'd6 - pos;
    end
endmodule

module aq_vdsp_ff1_scan_ctrl #(
    parameter int WIDTH = 64
) (
    input logic                    forever_cpuclk,
    input logic                    cpurst_b,
    aq_vdsp_ff1_scan_ctrl_if.slave bus
);
    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opnd_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    lzc_q;
    logic             found_q;
    logic             rem_q;
    logic             req_rdy_q;
    logic             res_vld_q;
    logic [CW-1:0]    res_lzc_q;
    logic             res_zero_q;
    logic             res_rem_q;

    logic [7:0]       scan_byte;
    logic [2:0]       ff1_out;
    logic             ff1_zero;
    logic             ff1_rem;
    logic [2:0]       ff1_step;
    logic [CW-1:0]    lzc_d;
    logic             found_d;
    logic             rem_d;
    logic             term_d;

    aq_vdsp_8_bit_ff1 u_ff1 (
        .src  (scan_byte),
        .out  (ff1_out),
        .zero (ff1_zero),
        .rem  (ff1_rem)
    );

    always_comb begin
        scan_byte = opnd_q[{idx_q, 3'b000} +: 8];
        ff1_step  = ff1_out + 3'd1;
        lzc_d     = lzc_q;
        found_d   = found_q;
        rem_d     = rem_q;
        if (!found_q) begin
            if (ff1_zero) begin
                lzc_d = lzc_q + CW'(8);
            end else begin
                lzc_d   = lzc_q + CW'(ff1_step);
                found_d = 1'b1;
                rem_d   = ff1_rem;
            end
        end else begin
            rem_d = rem_q & (scan_byte == 8'hFF);
        end
        term_d = (idx_q == '0) || (found_d && !rem_d);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            idx_q      <= '0;
            lzc_q      <= '0;
            found_q    <= 1'b0;
            rem_q      <= 1'b1;
            req_rdy_q  <= 1'b1;
            res_vld_q  <= 1'b0;
            res_lzc_q  <= '0;
            res_zero_q <= 1'b0;
            res_rem_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= IDLE;
            req_rdy_q  <= 1'b1;
            res_vld_q  <= 1'b0;
            res_lzc_q  <= '0;
            res_zero_q <= 1'b0;
            res_rem_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_vld && req_rdy_q) begin
                        // Leading-sign count becomes a leading-zero count on the inverted operand.
                        opnd_q    <= (bus.req_signed && bus.req_src[WIDTH-1]) ? ~bus.req_src : bus.req_src;
                        idx_q     <= IW'(NB - 1);
                        lzc_q     <= '0;
                        found_q   <= 1'b0;
                        rem_q     <= 1'b1;
                        req_rdy_q <= 1'b0;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    lzc_q   <= lzc_d;
                    found_q <= found_d;
                    rem_q   <= rem_d;
                    if (term_d) begin
                        state_q    <= DONE;
                        res_vld_q  <= 1'b1;
                        res_lzc_q  <= found_d ? lzc_d : CW'(WIDTH);
                        res_zero_q <= !found_d;
                        res_rem_q  <= rem_d;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_rdy) begin
                        state_q   <= IDLE;
                        res_vld_q <= 1'b0;
                        req_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    req_rdy_q <= 1'b1;
                    res_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy  = req_rdy_q;
    assign bus.res_vld  = res_vld_q;
    assign bus.res_lzc  = res_lzc_q;
    assign bus.res_zero = res_zero_q;
    assign bus.res_rem  = res_rem_q;
endmodule

// File: tb/tb_aq_vdsp_ff1_scan_ctrl.sv
module tb_aq_vdsp_ff1_scan_ctrl;
    logic        clk;
    logic        rst_b;
    int unsigned cyc;
    int unsigned n_chk;
    int unsigned n_fail;

    typedef struct {
        logic [6:0]  lzc;
        logic        zero;
        logic        rem;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [63:0] src;
        logic        sgn;
        logic [6:0]  lzc;
        logic        zero;
        logic        rem;
        int unsigned lat;
    } vec_t;

    exp_t sbq[$];

    aq_vdsp_ff1_scan_ctrl_if #(.WIDTH(64)) bus ();

    aq_vdsp_ff1_scan_ctrl #(.WIDTH(64)) u_dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: on each rising res_vld, pop and compare the expected result.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_vld === 1'b1 && !prev) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_res: got res_vld=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("res_lzc", 64'(bus.res_lzc), 64'(e.lzc));
                    chk("res_zero", 64'(bus.res_zero), 64'(e.zero));
                    chk("res_rem", 64'(bus.res_rem), 64'(e.rem));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end
            prev = (bus.res_vld === 1'b1);
        end
    end

    // Called at a negedge; leaves the bench at a negedge.
    task automatic issue(input vec_t v);
        int unsigned w;
        w = 0;
        while (bus.req_rdy !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (bus.req_rdy !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_rdy_timeout: got 0 expected 1");
            return;
        end
        bus.req_src    = v.src;
        bus.req_signed = v.sgn;
        bus.req_vld    = 1'b1;
        sbq.push_back('{v.lzc, v.zero, v.rem, cyc + v.lat});
        @(negedge clk);
        bus.req_vld    = 1'b0;
        bus.req_src    = ~v.src;
        bus.req_signed = ~v.sgn;
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while ((sbq.size() != 0 || bus.res_vld === 1'b1 || bus.req_rdy !== 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
    endtask

    vec_t vecs[11] = '{
        '{64'h0000_0000_0000_0000, 1'b0, 7'd64, 1'b1, 1'b1, 9},
        '{64'h8000_0000_0000_0000, 1'b0, 7'd0,  1'b0, 1'b0, 2},
        '{64'h0001_FFFF_FFFF_FFFF, 1'b0, 7'd15, 1'b0, 1'b1, 9},
        '{64'h0001_FFFF_FFFF_FFFE, 1'b0, 7'd15, 1'b0, 1'b0, 9},
        '{64'h0003_7FFF_0000_0000, 1'b0, 7'd14, 1'b0, 1'b0, 4},
        '{64'hFFFF_FFFF_FFFF_FF00, 1'b1, 7'd56, 1'b0, 1'b1, 9},
        '{64'hFFFF_FFFF_FFFF_FF00, 1'b0, 7'd0,  1'b0, 1'b0, 9},
        '{64'h0000_0000_0000_0001, 1'b1, 7'd63, 1'b0, 1'b1, 9},
        '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd64, 1'b1, 1'b1, 9},
        '{64'h0F00_0000_0000_0000, 1'b0, 7'd4,  1'b0, 1'b0, 3},
        '{64'h0000_0000_0000_0080, 1'b0, 7'd56, 1'b0, 1'b0, 9}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        logic        seen;
        n_chk = 0;
        n_fail = 0;
        rst_b = 1'b0;
        bus.flush = 1'b0;
        bus.req_vld = 1'b0;
        bus.req_src = '0;
        bus.req_signed = 1'b0;
        bus.res_rdy = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_res_vld", 64'(bus.res_vld), 64'd0);
        chk("rst_res_lzc", 64'(bus.res_lzc), 64'd0);
        chk("rst_res_zero", 64'(bus.res_zero), 64'd0);
        chk("rst_res_rem", 64'(bus.res_rem), 64'd0);
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
        rst_b = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) issue(vecs[i]);
        drain();

        // Result held under back-pressure.
        bus.res_rdy = 1'b0;
        issue('{64'h0000_0000_0000_00F0, 1'b0, 7'd56, 1'b0, 1'b0, 9});
        w = 0;
        while (bus.res_vld !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_res_vld_seen", 64'(bus.res_vld), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_vld", 64'(bus.res_vld), 64'd1);
            chk("bp_hold_lzc", 64'(bus.res_lzc), 64'd56);
            chk("bp_hold_rem", 64'(bus.res_rem), 64'd0);
            chk("bp_req_rdy", 64'(bus.req_rdy), 64'd0);
        end
        bus.res_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_vld", 64'(bus.res_vld), 64'd0);
        chk("bp_release_rdy", 64'(bus.req_rdy), 64'd1);
        drain();

        // Flush in SCAN cycle 3 of an all-zero operand.
        bus.req_src = '0;
        bus.req_signed = 1'b0;
        bus.req_vld = 1'b1;
        @(negedge clk);
        bus.req_vld = 1'b0;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_req_rdy", 64'(bus.req_rdy), 64'd1);
        chk("flush_res_vld", 64'(bus.res_vld), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_vld === 1'b1) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush in IDLE wins over a pending request.
        bus.req_vld = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.req_vld = 1'b0;
        bus.flush = 1'b0;
        chk("flush_idle_not_accepted", 64'(bus.req_rdy), 64'd1);

        // Leave a nonzero result on the outputs, then reset mid-scan.
        issue(vecs[2]);
        drain();
        bus.req_src = '0;
        bus.req_vld = 1'b1;
        @(negedge clk);
        bus.req_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        chk("mrst_res_vld", 64'(bus.res_vld), 64'd0);
        chk("mrst_res_lzc", 64'(bus.res_lzc), 64'd0);
        chk("mrst_res_zero", 64'(bus.res_zero), 64'd0);
        chk("mrst_res_rem", 64'(bus.res_rem), 64'd0);
        chk("mrst_req_rdy", 64'(bus.req_rdy), 64'd1);
        rst_b = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.res_vld === 1'b1) seen = 1'b1;
        end
        chk("mrst_no_result", 64'(seen), 64'd0);

        // Normal operation resumes after reset.
        issue(vecs[9]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
